// File: rtl/madd_err_pkg.sv
// Shared types and constants for the a*b+c approximate-circuit error sweep.
// Other checkers of the same circuit reuse the exact-model function below.
package madd_err_pkg;

  localparam int VEC_W    = 6;
  localparam int OUT_W    = 4;
  localparam int CNT_W    = 7;
  localparam int SUM_W    = 10;
  localparam int NUM_VECS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweepState_t;

  // Vector layout: a = vec[1:0], b = vec[3:2], c = vec[5:4]; result fits in 0..12.
  function automatic logic [OUT_W-1:0] exactMadd(input logic [VEC_W-1:0] vec);
    logic [OUT_W-1:0] a;
    logic [OUT_W-1:0] b;
    logic [OUT_W-1:0] c;
    a = {2'b00, vec[1:0]};
    b = {2'b00, vec[3:2]};
    c = {2'b00, vec[5:4]};
    return (a * b) + c;
  endfunction

endpackage

// File: rtl/madd_exact.sv
// Combinational exact reference for the 2x2-bit multiply-add circuit.
// Kept standalone so other checkers of the same circuit can instantiate it.
module madd_exact
  import madd_err_pkg::*;
(
  input  logic [VEC_W-1:0] i_vec,
  output logic [OUT_W-1:0] o_exact
);

  assign o_exact = exactMadd(i_vec);

endmodule

// File: rtl/madd_err_sweep.sv
// Exhaustive error sweep of an approximate a*b+c circuit over all 64 inputs,
// reporting max/count/sum of absolute error and the first vector over threshold.
module madd_err_sweep
  import madd_err_pkg::VEC_W, madd_err_pkg::OUT_W, madd_err_pkg::CNT_W,
         madd_err_pkg::SUM_W, madd_err_pkg::sweepState_t,
         madd_err_pkg::IDLE, madd_err_pkg::SWEEP, madd_err_pkg::DRAIN,
         madd_err_pkg::DONE;
#(
  parameter int unsigned ET       = 5,
  parameter int unsigned NUM_VECS = madd_err_pkg::NUM_VECS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] stim,
  input  logic [OUT_W-1:0] approx_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] max_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_err,
  output logic             pass,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_VECS);
  localparam logic [OUT_W:0]   L_ET     = (OUT_W + 1)'(ET);
  localparam logic [SUM_W-1:0] SUM_MAX  = '1;

  sweepState_t      r_state;
  sweepState_t      w_nextState;
  logic [VEC_W-1:0] r_stim;
  logic [VEC_W-1:0] r_s1Vec;
  logic [OUT_W-1:0] r_s1Err;
  logic             r_s1Valid;
  logic [OUT_W-1:0] r_maxErr;
  logic [CNT_W-1:0] r_errCnt;
  logic [SUM_W-1:0] r_sumErr;
  logic             r_pass;
  logic             r_done;
  logic [VEC_W-1:0] r_firstFailVec;
  logic             r_firstFailValid;

  logic [OUT_W-1:0] w_exact;
  logic [OUT_W:0]   w_diff;
  logic [OUT_W-1:0] w_err;
  logic [SUM_W:0]   w_sumNext;
  logic             w_inSweep;
  logic             w_accept;
  logic             w_abort;
  logic             w_clear;
  logic             w_lastVec;

  madd_exact u_exact (
    .i_vec   (r_stim),
    .o_exact (w_exact)
  );

  always_comb begin
    w_diff = '0;
    if (approx_out >= w_exact) begin
      w_diff = {1'b0, approx_out} - {1'b0, w_exact};
    end else begin
      w_diff = {1'b0, w_exact} - {1'b0, approx_out};
    end
  end

  // The top difference bit can never be set; saturating keeps the narrowing explicit.
  assign w_err = w_diff[OUT_W] ? '1 : w_diff[OUT_W-1:0];

  assign w_inSweep = (r_state == SWEEP);
  assign w_accept  = (r_state == IDLE) && start && !abort;
  assign w_abort   = ((r_state == SWEEP) || (r_state == DRAIN)) && abort;
  assign w_clear   = w_accept || w_abort;
  assign w_lastVec = (r_stim == LAST_VEC);
  assign w_sumNext = {1'b0, r_sumErr} + (SUM_W + 1)'(r_s1Err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SWEEP;
      SWEEP: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_lastVec) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN:   w_nextState = abort ? IDLE : DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Stage 1: one cycle per vector, capture its error alongside the vector itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stim    <= '0;
      r_s1Vec   <= '0;
      r_s1Err   <= '0;
      r_s1Valid <= 1'b0;
    end else if (w_clear) begin
      r_stim    <= '0;
      r_s1Vec   <= '0;
      r_s1Err   <= '0;
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Valid <= w_inSweep;
      if (w_inSweep) begin
        r_s1Err <= w_err;
        r_s1Vec <= r_stim;
        if (!w_lastVec) begin
          r_stim <= r_stim + VEC_W'(1);
        end
      end
    end
  end

  // Stage 2: accumulate; pass and done are settled on the edge that leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_maxErr         <= '0;
      r_errCnt         <= '0;
      r_sumErr         <= '0;
      r_pass           <= 1'b0;
      r_done           <= 1'b0;
      r_firstFailVec   <= '0;
      r_firstFailValid <= 1'b0;
    end else if (w_clear) begin
      r_maxErr         <= '0;
      r_errCnt         <= '0;
      r_sumErr         <= '0;
      r_pass           <= 1'b0;
      r_done           <= 1'b0;
      r_firstFailVec   <= '0;
      r_firstFailValid <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_pass <= ({1'b0, r_maxErr} <= L_ET);
      end
      if (r_s1Valid) begin
        if (r_s1Err > r_maxErr) begin
          r_maxErr <= r_s1Err;
        end
        if ((r_s1Err != '0) && (r_errCnt != CNT_MAX)) begin
          r_errCnt <= r_errCnt + CNT_W'(1);
        end
        r_sumErr <= w_sumNext[SUM_W] ? SUM_MAX : w_sumNext[SUM_W-1:0];
        if (!r_firstFailValid && ({1'b0, r_s1Err} > L_ET)) begin
          r_firstFailVec   <= r_s1Vec;
          r_firstFailValid <= 1'b1;
        end
      end
    end
  end

  assign stim             = r_stim;
  assign busy             = (r_state == SWEEP) || (r_state == DRAIN);
  assign done             = r_done;
  assign max_err          = r_maxErr;
  assign err_cnt          = r_errCnt;
  assign sum_err          = r_sumErr;
  assign pass             = r_pass;
  assign first_fail_vec   = r_firstFailVec;
  assign first_fail_valid = r_firstFailValid;

  // Saturation limits cannot be reached with one error per vector; flag if they ever are.
  aErrCntBound: assert property (@(posedge clk) disable iff (!rst_n)
    r_errCnt <= CNT_MAX);
  aSumNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
    r_s1Valid |-> !w_sumNext[SUM_W]);
  aStimNoWrap: assert property (@(posedge clk) disable iff (!rst_n)
    (w_inSweep && w_lastVec && !abort) |=> (r_stim == LAST_VEC));

endmodule

// File: doc/madd_err_sweep.md
MADD_ERR_SWEEP -- requirements
Module: madd_err_sweep

Interface
REQ-001 SHALL have parameter ET, default 5: error threshold; a vector fails when abs error > ET.
REQ-002 SHALL have parameter NUM_VECS, default 64: number of swept input vectors (fixed to the full 6-bit input space).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  sweep request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  cancel running sweep.
REQ-007 SHALL have port stim  output  6  registered vector driven to the approximate circuit's in5..in0 (stim[k] = in_k).
REQ-008 SHALL have port approx_out  input  4  combinational response of the approximate circuit, out3..out0.
REQ-009 SHALL have port busy  output  1  high in SWEEP and DRAIN.
REQ-010 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have ports max_err (4), err_cnt (7), sum_err (10), pass (1), first_fail_vec (6), first_fail_valid (1), all outputs: result registers.

Function
REQ-012 SHALL decode each vector as a = stim[1:0], b = stim[3:2], c = stim[5:4], with exact = a*b + c, unsigned 4-bit, range 0..12.
REQ-013 SHALL compute err = |approx_out - exact| at 5-bit internal width, then truncate to 4 bits, which is lossless since err <= 15.
REQ-014 SHALL use FSM states IDLE, SWEEP, DRAIN, DONE; reset state IDLE.
REQ-015 SHALL on IDLE with start=1 and abort=0: clear all result registers, set stim=0 and go to SWEEP on the next edge.
REQ-016 SHALL in SWEEP present stim for exactly one cycle, then register err for that vector (stage 1) and increment stim.
REQ-017 SHALL accumulate from the stage-1 register one cycle later (stage 2): max_err = max; err_cnt += (err != 0); sum_err += err.
REQ-018 SHALL, on the first vector with err > ET, capture first_fail_vec = that vector and set first_fail_valid = 1; later failures leave both unchanged.
REQ-019 SHALL go SWEEP -> DRAIN after stim = 63 is presented; stim SHALL hold 63 and never wrap to 0 inside a sweep.
REQ-020 SHALL use one DRAIN cycle to accumulate the last vector, then go to DONE, where done = 1 for exactly one cycle, pass = (max_err <= ET), and then return to IDLE.
REQ-021 SHALL make the latency from the start-accepting edge to done high equal 66 cycles.
REQ-022 SHALL hold results stable in IDLE until the next accepted start.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL on abort=1 in SWEEP or DRAIN go to IDLE next edge, clear results and stim, and produce no done pulse.
REQ-025 SHALL give abort priority when start and abort are both high in IDLE, so the sweep does not start.
REQ-026 SHALL saturate err_cnt at 64 and sum_err at 1023 (unreachable by construction but asserted).

Reset
REQ-027 SHALL on rst_n low, asynchronously set state=IDLE, stim=0, busy=0, done=0, max_err=0, err_cnt=0, sum_err=0, pass=0, first_fail_vec=0, first_fail_valid=0 and both pipeline registers to 0.
REQ-028 SHALL, on reset mid-sweep, discard partial results with no done pulse; it SHALL require a new start after deassertion.

Structure
REQ-029 SHALL take from shared package madd_err_pkg: the state enum, NUM_VECS, the width constants (VEC_W=6, OUT_W=4, CNT_W=7, SUM_W=10) and the exact a*b+c function.
REQ-030 SHALL contain one sub-module, madd_exact (combinational exact reference, 6-bit in, 4-bit out), which is reusable by other checkers.

Verification
REQ-031 SHALL cover: approx_out tied to exact model -> done at cycle 66; max_err=0, err_cnt=0, sum_err=0, pass=1, first_fail_valid=0.
REQ-032 SHALL cover: approx_out=0 constant -> max_err=12, err_cnt=57, sum_err=240, pass=0, first_fail_vec=11, first_fail_valid=1.
REQ-033 SHALL cover: approx_out = exact+1 -> max_err=1, err_cnt=64, sum_err=64, pass=1.
REQ-034 SHALL cover: abort at cycle 20 of SWEEP -> IDLE next cycle, results 0, no done; restart with start -> normal 66-cycle sweep.
REQ-035 SHALL cover: start pulsed while busy, plus start and abort together in IDLE -> both ignored; busy/state unchanged.
REQ-036 SHALL cover: rst_n low at cycle 30 of a sweep -> all outputs 0 immediately (asynchronously), no done, IDLE after release.
